// File: rtl/mem_arb_pkg.sv
// Purpose: shared encodings for the I/D memory arbiter (FSM states, grant ids).
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/dff.sv
// Purpose: generic register cell with synchronous active-high reset to RST_VAL.
// Latency: 1 cycle d -> q.
// Backpressure: none; loads every cycle.
module dff #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/mem_arb_pick.sv
// Purpose: combinational winner selection between the I and D requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the loser simply is not picked this cycle.
// Ports: i_req/d_req pending requests, last = most recent grant,
//        any_req = someone is asking, win = GNT_I / GNT_D.
// Config: MEM_ARB_RR_EN selects round-robin on a tie; otherwise D wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last,
    output logic any_req,
    output logic win
);

`ifdef MEM_ARB_RR_EN
    // On a tie hand the grant to whichever port did not win last time.
    always_comb begin
        any_req = i_req | d_req;
        win     = GNT_I;
        if (i_req && d_req) win = (last == GNT_I) ? GNT_D : GNT_I;
        else if (d_req)     win = GNT_D;
    end
`else
    // Fixed priority: D always wins a tie; last is only kept for debug.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        any_req = i_req | d_req;
        win     = d_req ? GNT_D : GNT_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one mem_system between the I-fetch and D-memory ports, one transaction per grant.
// Latency: hits complete in the request cycle; misses complete in the cycle mem_system raises MDone.
// Backpressure: loser / pending port sees Stall=1 until its Done pulse; grant held through BUSY.
// Ports: I side (IAddr, IRd -> IDataOut, IDone, IStall), D side (DAddr, DDataIn, DRd, DWr ->
//        DDataOut, DDone, DStall), mem_system side (MAddr, MDataIn, MRd, MWr <- MDataOut, MDone,
//        MStall, MCacheHit, MErr), CacheHit and err status. Optional macro: MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IAddr,
    input  logic        IRd,
    output logic [15:0] IDataOut,
    output logic        IDone,
    output logic        IStall,
    input  logic [15:0] DAddr,
    input  logic [15:0] DDataIn,
    input  logic        DRd,
    input  logic        DWr,
    output logic [15:0] DDataOut,
    output logic        DDone,
    output logic        DStall,
    output logic        CacheHit,
    output logic [15:0] MAddr,
    output logic [15:0] MDataIn,
    output logic        MRd,
    output logic        MWr,
    input  logic [15:0] MDataOut,
    input  logic        MDone,
    input  logic        MStall,
    input  logic        MCacheHit,
    input  logic        MErr,
    output logic        err
);

    logic state_q, state_d;
    logic grant_q, grant_d;
    logic last_q,  last_d;

    dff #(.WIDTH(1), .RST_VAL(IDLE))  u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_q));
    dff #(.WIDTH(1), .RST_VAL(GNT_I)) u_grant (.clk(clk), .rst(rst), .d(grant_d), .q(grant_q));
    dff #(.WIDTH(1), .RST_VAL(GNT_D)) u_last  (.clk(clk), .rst(rst), .d(last_d),  .q(last_q));

    logic i_req, d_req, any_req, win;
    logic is_idle, issue, sel, sel_req, done_now, run;
    logic unused_mstall;

    // MDone already covers every wait; the stall line carries no extra information here.
    assign unused_mstall = MStall;

    assign i_req = IRd;
    assign d_req = DRd | DWr;

    mem_arb_pick u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .last   (last_q),
        .any_req(any_req),
        .win    (win)
    );

    assign run     = ~rst;
    assign is_idle = (state_q == IDLE);
    assign issue   = is_idle & any_req;
    // In IDLE the fresh winner owns the bus; in BUSY the registered grant does.
    assign sel     = is_idle ? win : grant_q;
    assign sel_req = (sel == GNT_D) ? d_req : i_req;
    // A completion that ends the current transaction (the owner may have dropped it in BUSY).
    assign done_now = MDone & (issue | ~is_idle);

    always_comb begin
        MAddr    = 16'h0000;
        MDataIn  = 16'h0000;
        MRd      = 1'b0;
        MWr      = 1'b0;
        IDone    = 1'b0;
        DDone    = 1'b0;
        IDataOut = 16'h0000;
        DDataOut = 16'h0000;
        IStall   = 1'b0;
        DStall   = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        if (run) begin
            if (issue || !is_idle) begin
                MAddr   = (sel == GNT_D) ? DAddr : IAddr;
                MDataIn = (sel == GNT_D) ? DDataIn : 16'h0000;
            end
            // Strobes only in the issue cycle: mem_system latches them once.
            if (issue) begin
                MRd = (sel == GNT_D) ? DRd : IRd;
                MWr = (sel == GNT_D) & DWr;
            end
            IDone    = done_now & (sel == GNT_I) & i_req;
            DDone    = done_now & (sel == GNT_D) & d_req;
            IDataOut = IDone ? MDataOut : 16'h0000;
            DDataOut = DDone ? MDataOut : 16'h0000;
            IStall   = i_req & ~IDone;
            DStall   = d_req & ~DDone;
            CacheHit = (IDone | DDone) & MCacheHit;
            err      = MErr | (DRd & DWr) | (~is_idle & ~sel_req);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (is_idle) begin
            if (issue) begin
                if (MDone) begin
                    last_d = win;
                end else begin
                    state_d = BUSY;
                    grant_d = win;
                end
            end
        end else if (MDone) begin
            state_d = IDLE;
            last_d  = grant_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IAddr, DAddr, DDataIn, MDataOut;
    logic        IRd, DRd, DWr, MDone, MStall, MCacheHit, MErr;
    logic [15:0] IDataOut, DDataOut, MAddr, MDataIn;
    logic        IDone, IStall, DDone, DStall, CacheHit, MRd, MWr, err;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .IAddr(IAddr), .IRd(IRd), .IDataOut(IDataOut), .IDone(IDone), .IStall(IStall),
        .DAddr(DAddr), .DDataIn(DDataIn), .DRd(DRd), .DWr(DWr),
        .DDataOut(DDataOut), .DDone(DDone), .DStall(DStall),
        .CacheHit(CacheHit), .MAddr(MAddr), .MDataIn(MDataIn), .MRd(MRd), .MWr(MWr),
        .MDataOut(MDataOut), .MDone(MDone), .MStall(MStall), .MCacheHit(MCacheHit),
        .MErr(MErr), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ird, drd, dwr, mdone, mhit, merr;
        logic [15:0] iaddr, daddr, ddin, mdout;
        logic mrd, mwr, idone, ddone, istall, dstall, hit, er;
        logic [15:0] maddr, mdin, idout, ddout;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [15:0] data;
    } sb_t;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    vec_t tbl[6];
    vec_t v_idle;

    function automatic vec_t mk(
        logic ird, logic drd, logic dwr, logic [15:0] iaddr, logic [15:0] daddr,
        logic [15:0] ddin, logic mdone, logic [15:0] mdout, logic mhit, logic merr,
        logic mrd, logic mwr, logic [15:0] maddr, logic [15:0] mdin, logic idone,
        logic ddone, logic [15:0] idout, logic [15:0] ddout, logic istall, logic dstall,
        logic hit, logic er);
        vec_t v;
        v.ird = ird; v.drd = drd; v.dwr = dwr; v.iaddr = iaddr; v.daddr = daddr;
        v.ddin = ddin; v.mdone = mdone; v.mdout = mdout; v.mhit = mhit; v.merr = merr;
        v.mrd = mrd; v.mwr = mwr; v.maddr = maddr; v.mdin = mdin; v.idone = idone;
        v.ddone = ddone; v.idout = idout; v.ddout = ddout; v.istall = istall;
        v.dstall = dstall; v.hit = hit; v.er = er;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; expected completions go into the scoreboard now.
    task automatic apply(vec_t v);
        sb_t e;
        IRd = v.ird; DRd = v.drd; DWr = v.dwr; IAddr = v.iaddr; DAddr = v.daddr;
        DDataIn = v.ddin; MDone = v.mdone; MDataOut = v.mdout; MCacheHit = v.mhit;
        MErr = v.merr; MStall = ~v.mdone & (v.ird | v.drd | v.dwr);
        if (!rst && (v.idone || v.ddone)) begin
            e.is_d = v.ddone;
            e.data = v.ddone ? v.ddout : v.idout;
            sb.push_back(e);
        end
    endtask

    task automatic sb_check(string tag);
        sb_t e;
        if (IDone && DDone) begin
            checks++; errors++;
            $display("FAIL %s.both_done: IDone=1 DDone=1 expected at most one", tag);
        end else if (IDone || DDone) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s.sb_unexpected: done with empty scoreboard", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, ".sb_port"}, {31'd0, DDone}, {31'd0, e.is_d});
                chk({tag, ".sb_data"}, {16'd0, DDone ? DDataOut : IDataOut}, {16'd0, e.data});
            end
        end
    endtask

    task automatic check_all(string tag, vec_t v);
        chk({tag, ".MRd"},      {31'd0, MRd},      {31'd0, v.mrd});
        chk({tag, ".MWr"},      {31'd0, MWr},      {31'd0, v.mwr});
        chk({tag, ".MAddr"},    {16'd0, MAddr},    {16'd0, v.maddr});
        chk({tag, ".MDataIn"},  {16'd0, MDataIn},  {16'd0, v.mdin});
        chk({tag, ".IDone"},    {31'd0, IDone},    {31'd0, v.idone});
        chk({tag, ".DDone"},    {31'd0, DDone},    {31'd0, v.ddone});
        chk({tag, ".IDataOut"}, {16'd0, IDataOut}, {16'd0, v.idout});
        chk({tag, ".DDataOut"}, {16'd0, DDataOut}, {16'd0, v.ddout});
        chk({tag, ".IStall"},   {31'd0, IStall},   {31'd0, v.istall});
        chk({tag, ".DStall"},   {31'd0, DStall},   {31'd0, v.dstall});
        chk({tag, ".CacheHit"}, {31'd0, CacheHit}, {31'd0, v.hit});
        chk({tag, ".err"},      {31'd0, err},      {31'd0, v.er});
    endtask

    // One full cycle: drive, settle, compare, advance to just after the next edge.
    task automatic step(string tag, vec_t v);
        apply(v);
        #3;
        check_all(tag, v);
        sb_check(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic w;
        v_idle = mk(0,0,0,16'h0,16'h0,16'h0,0,16'h0,0,0, 0,0,16'h0,16'h0,0,0,16'h0,16'h0,0,0,0,0);

        tbl[0] = mk(0,0,0,16'h0040,16'h0080,16'h1111,1,16'hFFFF,1,0, 0,0,16'h0000,16'h0000,0,0,16'h0,16'h0,0,0,0,0);
        tbl[1] = mk(1,0,0,16'h0040,16'h0080,16'h0000,1,16'h1234,1,0, 1,0,16'h0040,16'h0000,1,0,16'h1234,16'h0,0,0,1,0);
        tbl[2] = mk(0,1,0,16'h0040,16'h0100,16'h0077,1,16'h5678,1,0, 1,0,16'h0100,16'h0077,0,1,16'h0,16'h5678,0,0,1,0);
        tbl[3] = mk(0,0,1,16'h0040,16'h0200,16'hCAFE,1,16'h1111,1,0, 0,1,16'h0200,16'hCAFE,0,1,16'h0,16'h1111,0,0,1,0);
        tbl[4] = mk(0,1,1,16'h0040,16'h0300,16'h00AA,1,16'h2222,0,0, 1,1,16'h0300,16'h00AA,0,1,16'h0,16'h2222,0,0,0,1);
        tbl[5] = mk(1,0,0,16'h0044,16'h0300,16'h0000,1,16'h3333,1,1, 1,0,16'h0044,16'h0000,1,0,16'h3333,16'h0,0,0,1,1);

        // Reset: everything quiet even with requests, MDone and MErr driven.
        rst = 1'b1;
        apply(v_idle);
        @(posedge clk); #1;
        step("reset", mk(1,1,1,16'h0040,16'h0080,16'h1111,1,16'hFFFF,1,1, 0,0,16'h0,16'h0,0,0,16'h0,16'h0,0,0,0,0));
        rst = 1'b0;

        // Simultaneous hits straight out of reset (last=D, so round-robin starts with I).
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            w = k[0];
`else
            w = 1'b1;
`endif
            v = mk(1,1,0,16'h0010,16'h0020,16'h0000,1,16'h0A00 + 16'(k),1,0,
                   1,0, w ? 16'h0020 : 16'h0010, 16'h0000, ~w, w,
                   w ? 16'h0 : 16'h0A00 + 16'(k), w ? 16'h0A00 + 16'(k) : 16'h0,
                   w, ~w, 1, 0);
            step($sformatf("tie%0d", k), v);
        end
        step("tie_idle", v_idle);

        // Single-cycle table: hits, write, read+write error, MErr pass-through.
        for (int i = 0; i < 6; i++) step($sformatf("tbl%0d", i), tbl[i]);

        // D write miss completing 8 cycles after issue.
        step("wmiss_issue", mk(0,0,1,16'h0,16'h0800,16'hBEEF,0,16'h0,0,0, 0,1,16'h0800,16'hBEEF,0,0,16'h0,16'h0,0,1,0,0));
        for (int i = 0; i < 7; i++)
            step($sformatf("wmiss_busy%0d", i), mk(0,0,1,16'h0,16'h0800,16'hBEEF,0,16'h0,0,0, 0,0,16'h0800,16'hBEEF,0,0,16'h0,16'h0,0,1,0,0));
        step("wmiss_done", mk(0,0,1,16'h0,16'h0800,16'hBEEF,1,16'h5A5A,0,0, 0,0,16'h0800,16'hBEEF,0,1,16'h0,16'h5A5A,0,0,0,0));
        step("wmiss_idle", v_idle);

        // D read miss; I arrives mid-miss and is only issued after DDone.
        step("cont_issue", mk(0,1,0,16'h0500,16'h0300,16'h0,0,16'h0,0,0, 1,0,16'h0300,16'h0,0,0,16'h0,16'h0,0,1,0,0));
        step("cont_busy1", mk(0,1,0,16'h0500,16'h0300,16'h0,0,16'h0,0,0, 0,0,16'h0300,16'h0,0,0,16'h0,16'h0,0,1,0,0));
        step("cont_busy2", mk(1,1,0,16'h0500,16'h0300,16'h0,0,16'h0,0,0, 0,0,16'h0300,16'h0,0,0,16'h0,16'h0,1,1,0,0));
        step("cont_ddone", mk(1,1,0,16'h0500,16'h0300,16'h0,1,16'hABCD,0,0, 0,0,16'h0300,16'h0,0,1,16'h0,16'hABCD,1,0,0,0));
        step("cont_iissue", mk(1,0,0,16'h0500,16'h0300,16'h0,0,16'h0,0,0, 1,0,16'h0500,16'h0,0,0,16'h0,16'h0,1,0,0,0));
        step("cont_idone", mk(1,0,0,16'h0500,16'h0300,16'h0,1,16'h4444,1,0, 0,0,16'h0500,16'h0,1,0,16'h4444,16'h0,0,0,1,0));
        step("cont_idle", v_idle);

        // Granted port drops its request in BUSY: err, no Done, then back to IDLE.
        step("drop_issue", mk(0,1,0,16'h0,16'h0600,16'h0,0,16'h0,0,0, 1,0,16'h0600,16'h0,0,0,16'h0,16'h0,0,1,0,0));
        step("drop_busy",  mk(0,0,0,16'h0,16'h0600,16'h0,0,16'h0,0,0, 0,0,16'h0600,16'h0,0,0,16'h0,16'h0,0,0,0,1));
        step("drop_mdone", mk(0,0,0,16'h0,16'h0600,16'h0,1,16'hDEAD,1,0, 0,0,16'h0600,16'h0,0,0,16'h0,16'h0,0,0,0,1));
        step("drop_probe", mk(1,0,0,16'h0700,16'h0600,16'h0,1,16'h7777,1,0, 1,0,16'h0700,16'h0,1,0,16'h7777,16'h0,0,0,1,0));

        // Reset during BUSY: outputs 0, no Done, request re-issued from IDLE afterwards.
        step("rbusy_issue", mk(0,1,0,16'h0,16'h0900,16'h0,0,16'h0,0,0, 1,0,16'h0900,16'h0,0,0,16'h0,16'h0,0,1,0,0));
        step("rbusy_busy",  mk(0,1,0,16'h0,16'h0900,16'h0,0,16'h0,0,0, 0,0,16'h0900,16'h0,0,0,16'h0,16'h0,0,1,0,0));
        rst = 1'b1;
        step("rbusy_rst",   mk(0,1,0,16'h0,16'h0900,16'h0,1,16'h9999,1,0, 0,0,16'h0,16'h0,0,0,16'h0,16'h0,0,0,0,0));
        rst = 1'b0;
        step("rbusy_reiss", mk(0,1,0,16'h0,16'h0900,16'h0,0,16'h0,0,0, 1,0,16'h0900,16'h0,0,0,16'h0,16'h0,0,1,0,0));
        step("rbusy_done",  mk(0,1,0,16'h0,16'h0900,16'h0,1,16'h1357,0,0, 0,0,16'h0900,16'h0,0,1,16'h0,16'h1357,0,0,0,0));
        step("rbusy_idle",  v_idle);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
